// File: rtl/mem_arb.sv
// Arbiter sharing one 64-bit memory port between instruction fetch (I) and load/store (D).
// Optional MEM_ARB_RR_EN selects round-robin arbitration instead of D priority with starve limit.
module mem_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] im_req_addr,
  input  logic        im_req_valid,
  output logic        im_req_ready,
  output logic [63:0] im_resp_rdata,
  output logic        im_resp_valid,
  input  logic [63:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic [7:0]  dm_req_wmask,
  input  logic        dm_req_wen,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  output logic [63:0] dm_resp_rdata,
  output logic        dm_resp_valid,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  output logic        mem_req_wen,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  input  logic [63:0] mem_resp_rdata,
  input  logic        mem_resp_valid,
  output logic        arb_err
);
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e        state_q;
  logic          owner_d_q;
  logic          i_pend_q;
  logic [AW-1:0] i_addr_q;
  logic          d_pend_q;
  logic [AW-1:0] d_addr_q;
  logic [DW-1:0] d_wdata_q;
  logic [MW-1:0] d_wmask_q;
  logic          d_wen_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [MW-1:0] mem_wmask_q;
  logic          mem_wen_q;
  logic          mem_valid_q;
  logic          arb_err_q;

  logic resp_c, i_resp_c, d_resp_c;
  logic i_cap_c, i_drop_c, d_cap_c;
  logic grant_c, grant_d_c;

  // A slot frees on the edge its response returns, so ready includes that cycle.
  assign resp_c   = (state_q == RESP) && mem_resp_valid;
  assign i_resp_c = resp_c && !owner_d_q;
  assign d_resp_c = resp_c && owner_d_q;

  assign im_req_ready = !i_pend_q || i_resp_c;
  assign dm_req_ready = !d_pend_q || d_resp_c;
  assign i_cap_c      = im_req_valid && im_req_ready;
  assign i_drop_c     = im_req_valid && !im_req_ready;
  assign d_cap_c      = dm_req_valid && dm_req_ready;
  assign grant_c      = (state_q == IDLE) && (i_pend_q || d_pend_q);

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  // Contested grant goes to whoever did not win last time.
  assign grant_d_c = d_pend_q && !(i_pend_q && last_d_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b1;
    end else if (grant_c) begin
      last_d_q <= grant_d_c;
    end
  end
`else
  logic [CW-1:0] starve_q;

  // D wins unless I has been passed over STARVE_LIMIT times in a row.
  assign grant_d_c = d_pend_q && !(i_pend_q && (starve_q == CW'(STARVE_LIMIT)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (grant_c) begin
      if (!grant_d_c) begin
        starve_q <= '0;
      end else if (i_pend_q) begin
        starve_q <= starve_q + CW'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      i_pend_q    <= 1'b0;
      i_addr_q    <= '0;
      d_pend_q    <= 1'b0;
      d_addr_q    <= '0;
      d_wdata_q   <= '0;
      d_wmask_q   <= '0;
      d_wen_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      mem_wen_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      arb_err_q   <= 1'b0;
    end else begin
      if (i_cap_c) begin
        i_pend_q <= 1'b1;
        i_addr_q <= im_req_addr;
      end else if (i_resp_c) begin
        i_pend_q <= 1'b0;
      end
      if (i_drop_c) begin
        arb_err_q <= 1'b1;
      end
      if (d_cap_c) begin
        d_pend_q  <= 1'b1;
        d_addr_q  <= dm_req_addr;
        d_wdata_q <= dm_req_wdata;
        d_wmask_q <= dm_req_wmask;
        d_wen_q   <= dm_req_wen;
      end else if (d_resp_c) begin
        d_pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (grant_c) begin
            owner_d_q   <= grant_d_c;
            mem_valid_q <= 1'b1;
            state_q     <= REQ;
            if (grant_d_c) begin
              mem_addr_q  <= d_addr_q;
              mem_wdata_q <= d_wdata_q;
              mem_wmask_q <= d_wmask_q;
              mem_wen_q   <= d_wen_q;
            end else begin
              mem_addr_q  <= i_addr_q;
              mem_wdata_q <= '0;
              mem_wmask_q <= '0;
              mem_wen_q   <= 1'b0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (mem_resp_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_addr  = mem_addr_q;
  assign mem_req_wdata = mem_wdata_q;
  assign mem_req_wmask = mem_wmask_q;
  assign mem_req_wen   = mem_wen_q;
  assign mem_req_valid = mem_valid_q;
  assign arb_err       = arb_err_q;

  // Responses route straight through to the owner in the cycle they arrive.
  assign im_resp_valid = i_resp_c;
  assign im_resp_rdata = i_resp_c ? mem_resp_rdata : '0;
  assign dm_resp_valid = d_resp_c;
  assign dm_resp_rdata = d_resp_c ? mem_resp_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Randomized bench for mem_arb against a transaction-level reference model, plus directed scenarios.
module tb_mem_arb;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] im_req_addr;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [63:0] im_resp_rdata;
  logic        im_resp_valid;
  logic [63:0] dm_req_addr;
  logic [63:0] dm_req_wdata;
  logic [7:0]  dm_req_wmask;
  logic        dm_req_wen;
  logic        dm_req_valid;
  logic        dm_req_ready;
  logic [63:0] dm_resp_rdata;
  logic        dm_resp_valid;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_req_wen;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_resp_rdata;
  logic        mem_resp_valid;
  logic        arb_err;

  always #5 clk = ~clk;

  mem_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .im_req_addr(im_req_addr), .im_req_valid(im_req_valid), .im_req_ready(im_req_ready),
    .im_resp_rdata(im_resp_rdata), .im_resp_valid(im_resp_valid),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask),
    .dm_req_wen(dm_req_wen), .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_req_wen(mem_req_wen), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_valid(mem_resp_valid), .arb_err(arb_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: bus phase 0=free, 1=request offered, 2=awaiting response.
  int           ph;
  bit           m_own_d;
  bit           m_ip;
  logic [63:0]  m_ia;
  bit           m_dp;
  logic [63:0]  m_da, m_dw;
  logic [7:0]   m_dm;
  bit           m_dwen;
  logic [136:0] m_bus;
  bit           m_err;
  int           m_starve;
  bit           m_last_d;

  logic [63:0]  obs_q[$];
  bit           prev_mrv;
  int           i_resp_cnt, d_resp_cnt;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    ph = 0; m_own_d = 0; m_ip = 0; m_dp = 0; m_err = 0;
    m_starve = 0; m_last_d = 1; prev_mrv = 0;
    m_ia = '0; m_da = '0; m_dw = '0; m_dm = '0; m_dwen = 0; m_bus = '0;
  endtask

  task automatic drive_idle();
    im_req_valid = 0; im_req_addr = '0;
    dm_req_valid = 0; dm_req_addr = '0; dm_req_wdata = '0; dm_req_wmask = '0; dm_req_wen = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 0;
    #2;
    check("rst_mem_req_valid", 200'(mem_req_valid), 200'(0));
    check("rst_mem_req", 200'({mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata}), 200'(0));
    check("rst_ready", 200'({im_req_ready, dm_req_ready}), 200'(2'b11));
    check("rst_resp", 200'({im_resp_valid, im_resp_rdata, dm_resp_valid, dm_resp_rdata}), 200'(0));
    check("rst_arb_err", 200'(arb_err), 200'(0));
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit iv, input logic [63:0] ia, input bit dv, input logic [63:0] da,
                      input logic [63:0] dw, input logic [7:0] dm, input bit dwen,
                      input bit rdy, input bit rv, input logic [63:0] rd);
    bit r_i, r_d, i_free, d_free, pick_d;
    @(negedge clk);
    im_req_valid = iv; im_req_addr = ia;
    dm_req_valid = dv; dm_req_addr = da; dm_req_wdata = dw; dm_req_wmask = dm; dm_req_wen = dwen;
    mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_rdata = rd;
    #2;
    r_i    = (ph == 2) && rv && !m_own_d;
    r_d    = (ph == 2) && rv && m_own_d;
    i_free = !m_ip || r_i;
    d_free = !m_dp || r_d;
    check("mem_req_valid", 200'(mem_req_valid), 200'(ph == 1));
    if (ph == 1)
      check("mem_req_fields", 200'({mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata}), 200'(m_bus));
    check("req_ready", 200'({im_req_ready, dm_req_ready}), 200'({i_free, d_free}));
    check("resp", 200'({im_resp_valid, im_resp_rdata, dm_resp_valid, dm_resp_rdata}),
          200'({r_i, (r_i ? rd : 64'h0), r_d, (r_d ? rd : 64'h0)}));
    check("arb_err", 200'(arb_err), 200'(m_err));
    if (mem_req_valid && !prev_mrv) obs_q.push_back(mem_req_addr);
    prev_mrv = mem_req_valid;
    if (im_resp_valid) i_resp_cnt++;
    if (dm_resp_valid) d_resp_cnt++;

    if (ph == 0) begin
      if (m_ip || m_dp) begin
`ifdef MEM_ARB_RR_EN
        pick_d   = m_dp && !(m_ip && m_last_d);
        m_last_d = pick_d;
`else
        pick_d = m_dp && !(m_ip && m_starve == int'(LIMIT));
        if (!pick_d) m_starve = 0;
        else if (m_ip) m_starve++;
`endif
        m_own_d = pick_d;
        m_bus   = pick_d ? {m_dwen, m_dm, m_da, m_dw} : {1'b0, 8'h00, m_ia, 64'h0};
        ph      = 1;
      end
    end else if (ph == 1) begin
      if (rdy) ph = 2;
    end else if (rv) begin
      ph = 0;
    end
    if (r_i) m_ip = 0;
    if (r_d) m_dp = 0;
    if (iv) begin
      if (i_free) begin m_ip = 1; m_ia = ia; end
      else m_err = 1;
    end
    if (dv && d_free) begin
      m_dp = 1; m_da = da; m_dw = dw; m_dm = dm; m_dwen = dwen;
    end
  endtask

  task automatic nop(input bit rdy, input bit rv);
    step(0, '0, 0, '0, '0, '0, 0, rdy, rv, rnd64());
  endtask

  task automatic drain();
    for (int k = 0; k < 8; k++) nop(1, 1);
  endtask

  initial begin
    rst = 0;
    drive_idle();
    model_reset();
    do_reset();

    // Single fetch, response one cycle after acceptance
    obs_q.delete(); i_resp_cnt = 0; d_resp_cnt = 0;
    step(1, 64'h1000_0000, 0, '0, '0, '0, 0, 1, 0, '0);
    nop(1, 0);
    nop(1, 0);
    step(0, '0, 0, '0, '0, '0, 0, 1, 1, 64'h0000_0013_0000_0013);
    nop(1, 0);
    check("t1_addr", 200'(obs_q[0]), 200'(64'h1000_0000));
    check("t1_i_resp_cnt", 200'(i_resp_cnt), 200'(1));
    check("t1_d_resp_cnt", 200'(d_resp_cnt), 200'(0));

    // Simultaneous I fetch and D store
    drain();
    obs_q.delete();
    step(1, 64'h2000, 1, 64'h80, 64'hDEAD_BEEF, 8'h0F, 1, 1, 1, rnd64());
    for (int k = 0; k < 8; k++) nop(1, 1);
    check("t2_issue_cnt", 200'(obs_q.size()), 200'(2));
`ifdef MEM_ARB_RR_EN
    check("t2_first", 200'(obs_q[0]), 200'(64'h2000));
    check("t2_second", 200'(obs_q[1]), 200'(64'h80));
`else
    check("t2_first", 200'(obs_q[0]), 200'(64'h80));
    check("t2_second", 200'(obs_q[1]), 200'(64'h2000));
`endif

    // Continuous D traffic with one I request waiting
    drain();
    obs_q.delete();
    step(1, 64'h3000, 1, 64'h400, rnd64(), 8'hFF, 0, 1, 1, rnd64());
    for (int k = 0; k < 24; k++) step(0, '0, 1, 64'h400, rnd64(), 8'hFF, 0, 1, 1, rnd64());
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
      check($sformatf("t3_issue%0d", k), 200'(obs_q[k]), 200'((k == 0) ? 64'h3000 : 64'h400));
`else
      check($sformatf("t3_issue%0d", k), 200'(obs_q[k]), 200'((k == 4) ? 64'h3000 : 64'h400));
`endif
    end

    // Bus stalls request for several cycles; stray response pulses must be ignored
    drain();
    obs_q.delete(); d_resp_cnt = 0;
    step(0, '0, 1, 64'h500, 64'h1234_5678_9ABC_DEF0, 8'hA5, 1, 0, 1, rnd64());
    for (int k = 0; k < 6; k++) nop(0, 1);
    check("t4_no_early_resp", 200'(d_resp_cnt), 200'(0));
    nop(1, 0);
    nop(1, 1);
    check("t4_resp_cnt", 200'(d_resp_cnt), 200'(1));

    // Second fetch while the first is in flight is dropped
    drain();
    obs_q.delete(); i_resp_cnt = 0;
    step(1, 64'h6000, 0, '0, '0, '0, 0, 1, 0, '0);
    nop(1, 0);
    step(1, 64'h7000, 0, '0, '0, '0, 0, 1, 0, '0);
    nop(1, 1);
    drain();
    check("t5_arb_err", 200'(arb_err), 200'(1));
    check("t5_one_issue", 200'(obs_q.size()), 200'(1));
    check("t5_one_resp", 200'(i_resp_cnt), 200'(1));

    // Randomized traffic, then a phase with D always requesting
    for (int k = 0; k < 800; k++)
      step(($urandom % 4) == 0, rnd64(), ($urandom % 3) == 0, rnd64(), rnd64(), 8'($urandom),
           1'($urandom), ($urandom % 3) != 0, ($urandom % 2) == 0, rnd64());
    for (int k = 0; k < 400; k++)
      step(($urandom % 6) == 0, rnd64(), 1, rnd64(), rnd64(), 8'($urandom),
           1'($urandom), ($urandom % 4) != 0, ($urandom % 3) != 0, rnd64());

    // Reset while awaiting a response, then a stale response pulse
    begin
      bit reached = 0;
      for (int k = 0; k < 50 && !reached; k++) begin
        step(0, '0, 1, rnd64(), rnd64(), 8'hFF, 0, 1, 0, '0);
        reached = (ph == 2);
      end
      check("t6_reached_resp", 200'(reached), 200'(1));
    end
    do_reset();
    i_resp_cnt = 0; d_resp_cnt = 0;
    for (int k = 0; k < 4; k++) nop(1, 1);
    check("t6_no_resp", 200'({i_resp_cnt[7:0], d_resp_cnt[7:0]}), 200'(0));
    check("t6_ready", 200'({im_req_ready, dm_req_ready}), 200'(2'b11));
    check("t6_idle", 200'(mem_req_valid), 200'(0));

    for (int k = 0; k < 200; k++)
      step(($urandom % 3) == 0, rnd64(), ($urandom % 3) == 0, rnd64(), rnd64(), 8'($urandom),
           1'($urandom), ($urandom % 2) == 0, ($urandom % 2) == 0, rnd64());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
